mdu_iterative: RTL and testbench



---
 rtl/mdu_iterative_if.sv | 30 +++
 rtl/mdu_iterative.sv | 157 +++++++++++++++
 tb/tb_mdu_iterative.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_iterative_if.sv
// Multiply/divide unit bus: execute-stage launch, MTHI/MTLO writes, HI/LO readout and hazard stall.
// The master side (execute/decode stage) drives requests; the slave side (mdu_iterative) drives results.
interface mdu_iterative_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            mthi;
  logic            mtlo;
  logic [XLEN-1:0] wdata;
  logic            mf_req;
  logic            flush;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic            busy;
  logic            done;
  logic            stall_req;

  modport master (
    output start, op, a, b, mthi, mtlo, wdata, mf_req, flush,
    input  hi, lo, busy, done, stall_req
  );

  modport slave (
    input  start, op, a, b, mthi, mtlo, wdata, mf_req, flush,
    output hi, lo, busy, done, stall_req
  );
endinterface

// File: rtl/mdu_iterative.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO registers: one bit per cycle, result XLEN+1 edges after start.
// No backpressure: start is ignored while busy; stall_req holds off MFHI/MFLO until the result lands.
module mdu_iterative #(
  parameter int XLEN = 32
) (
  input logic          clk,
  input logic          reset_n,
  mdu_iterative_if.slave bus
);
  localparam int CNT_W = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  // acc/sh form the product pair for multiply, remainder/quotient pair for divide
  logic [XLEN-1:0]   acc;
  logic [XLEN-1:0]   sh;
  logic [XLEN-1:0]   opb;
  logic              is_div;
  logic              neg_res;
  logic              neg_rem;
  logic              div0;
  logic [XLEN-1:0]   hi_q;
  logic [XLEN-1:0]   lo_q;
  logic              done_q;

  logic              busy;
  logic              last_step;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic [XLEN:0]     mul_sum;
  logic [XLEN+1:0]   div_diff;
  logic              div_ok;
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   res_hi;
  logic [XLEN-1:0]   res_lo;

  assign busy      = (state != IDLE);
  assign last_step = (cnt == CNT_W'(XLEN - 1));

  // op[0] selects unsigned; signed ops run on magnitudes and fix signs at the end
  assign a_neg = ~bus.op[0] & bus.a[XLEN-1];
  assign b_neg = ~bus.op[0] & bus.b[XLEN-1];
  assign a_mag = a_neg ? -bus.a : bus.a;
  assign b_mag = b_neg ? -bus.b : bus.b;

  assign mul_sum  = {1'b0, acc} + (sh[0] ? {1'b0, opb} : '0);
  assign div_diff = {1'b0, acc, sh[XLEN-1]} - {2'b00, opb};
  assign div_ok   = ~div_diff[XLEN+1];

  assign prod     = {acc, sh};
  assign prod_fix = neg_res ? -prod : prod;

  always_comb begin
    res_hi = prod_fix[2*XLEN-1:XLEN];
    res_lo = prod_fix[XLEN-1:0];
    if (is_div) begin
      // with a zero divisor the dividend shifts straight into acc, so the
      // normal remainder sign rule reproduces the original dividend
      res_hi = neg_rem ? -acc : acc;
      res_lo = div0 ? '1 : (neg_res ? -sh : sh);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = CALC;
      CALC: begin
        if (bus.flush) begin
          state_nxt = IDLE;
        end else if (last_step) begin
          state_nxt = FIX;
        end
      end
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      acc     <= '0;
      sh      <= '0;
      opb     <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            cnt     <= '0;
            acc     <= '0;
            sh      <= a_mag;
            opb     <= b_mag;
            is_div  <= bus.op[1];
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg & bus.op[1];
            div0    <= (bus.b == '0);
          end
        end
        CALC: begin
          if (!bus.flush) begin
            cnt <= cnt + CNT_W'(1);
            if (is_div) begin
              acc <= div_ok ? div_diff[XLEN-1:0] : {acc[XLEN-2:0], sh[XLEN-1]};
              sh  <= {sh[XLEN-2:0], div_ok};
            end else begin
              {acc, sh} <= {mul_sum, sh[XLEN-1:1]};
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == IDLE) begin
        if (bus.mthi) hi_q <= bus.wdata;
        if (bus.mtlo) lo_q <= bus.wdata;
      end else if (state == FIX && !bus.flush) begin
        hi_q   <= res_hi;
        lo_q   <= res_lo;
        done_q <= 1'b1;
      end
    end
  end

  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.busy      = busy;
  assign bus.done      = done_q;
  assign bus.stall_req = busy & bus.mf_req;
endmodule

// File: tb/tb_mdu_iterative.sv
// Bench for mdu_iterative: directed vector table, multi-cycle corner sequences and randomized ops
// checked against an arithmetic reference model.
module tb_mdu_iterative;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mdu_iterative_if #(.XLEN(XLEN)) bus ();
  mdu_iterative #(.XLEN(XLEN)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int total = 0;
  int bad = 0;
  logic [31:0] model_hi = 32'h0;
  logic [31:0] model_lo = 32'h0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint          sp;
    longint unsigned up;
    int              sx;
    int              sy;
    sx = x;
    sy = y;
    case (o)
      2'd0: begin sp = longint'(sx) * longint'(sy); return sp; end
      2'd1: begin up = {32'h0, x} * {32'h0, y}; return up; end
      2'd2: begin
        if (y == 32'h0) return {x, 32'hFFFFFFFF};
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        return {32'(sx % sy), 32'(sx / sy)};
      end
      default: begin
        if (y == 32'h0) return {x, 32'hFFFFFFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  // kind: 0 none, 1 MTHI at loop cycle inj_cyc, 2 stray start at inj_cyc,
  //       3 MTHI alongside start, 4 flush alongside start
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] eh, input logic [31:0] el,
                        input int inj_cyc, input int kind, input bit mf);
    int n;
    int bcnt;
    bit got;
    bit stall_ok;
    n = 0; bcnt = 0; got = 1'b0; stall_ok = 1'b1;
    bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y; bus.mf_req = mf;
    if (kind == 3) begin bus.mthi = 1'b1; bus.wdata = 32'hC0DE0003; end
    if (kind == 4) bus.flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0; bus.mthi = 1'b0; bus.flush = 1'b0;
    bus.a = $urandom; bus.b = $urandom;
    if (kind == 3) begin
      model_hi = 32'hC0DE0003;
      check("mthi_with_start", bus.hi, model_hi);
    end
    if (bus.busy) bcnt++;
    if (mf && bus.stall_req !== bus.busy) stall_ok = 1'b0;
    while (!got && n < 100) begin
      if (n == inj_cyc && kind == 1) begin bus.mthi = 1'b1; bus.wdata = 32'hDEADBEEF; end
      if (n == inj_cyc && kind == 2) begin
        bus.start = 1'b1; bus.op = ~o; bus.a = $urandom; bus.b = $urandom;
      end
      @(posedge clk);
      n++;
      @(negedge clk);
      bus.start = 1'b0;
      if (n - 1 == inj_cyc && kind == 1) begin
        bus.mthi = 1'b0;
        if (n < 33) check("mthi_busy_drop", bus.hi, model_hi);
      end
      if (bus.done) begin
        got = 1'b1;
        check("busy_on_done", bus.busy, 0);
        if (mf) check("stall_on_done", bus.stall_req, 0);
      end else begin
        if (bus.busy) bcnt++;
        if (mf && bus.stall_req !== bus.busy) stall_ok = 1'b0;
      end
    end
    check("latency", n, 33);
    check("busy_cycles", bcnt, 33);
    check("hi", bus.hi, eh);
    check("lo", bus.lo, el);
    if (mf) check("stall_while_busy", stall_ok, 1);
    model_hi = eh;
    model_lo = el;
    bus.mf_req = 1'b0;
  endtask

  task automatic watch_no_done(input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    check(nm, seen, 0);
  endtask

  initial begin
    logic [1:0]  o;
    logic [31:0] x;
    logic [31:0] y;
    logic [63:0] e;

    vecs[0]  = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{2'd0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[2]  = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[3]  = '{2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4]  = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5]  = '{2'd3, 32'd100,      32'd7,        32'd2,        32'd14};
    vecs[6]  = '{2'd3, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};
    vecs[7]  = '{2'd2, 32'hFFFFFFF0, 32'd0,        32'hFFFFFFF0, 32'hFFFFFFFF};
    vecs[8]  = '{2'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    vecs[9]  = '{2'd2, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'd2};
    vecs[10] = '{2'd1, 32'h80000000, 32'd2,        32'd1,        32'd0};
    vecs[11] = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1};

    bus.start = 1'b0; bus.op = 2'd0; bus.a = '0; bus.b = '0;
    bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.wdata = '0; bus.mf_req = 1'b0; bus.flush = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_hi", bus.hi, 0);
    check("reset_lo", bus.lo, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // directed table; first entry also holds mf_req to exercise the stall
    for (int i = 0; i < 12; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, -1, 0, i == 0);

    // stray start mid-operation must be ignored
    run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 5, 2, 1'b1);
    // MTHI while in CALC and on the FIX edge are both dropped
    run_op(2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 10, 1, 1'b0);
    run_op(2'd0, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 32, 1, 1'b0);
    // MTHI with start is applied then overwritten; flush with start in IDLE is ignored
    run_op(2'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, -1, 3, 1'b0);
    run_op(2'd3, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, -1, 4, 1'b0);
    @(negedge clk);

    // MTHI/MTLO in IDLE, then flush mid-operation
    bus.mthi = 1'b1; bus.wdata = 32'h1234;
    @(negedge clk);
    bus.mthi = 1'b0; bus.mtlo = 1'b1; bus.wdata = 32'h5678;
    check("mthi_idle", bus.hi, 32'h1234);
    @(negedge clk);
    bus.mtlo = 1'b0;
    check("mtlo_idle", bus.lo, 32'h5678);
    bus.start = 1'b1; bus.op = 2'd0; bus.a = 32'd3; bus.b = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_busy", bus.busy, 0);
    check("flush_done", bus.done, 0);
    check("flush_hi", bus.hi, 32'h1234);
    check("flush_lo", bus.lo, 32'h5678);
    watch_no_done("flush_no_done");

    // reset mid-operation
    bus.start = 1'b1; bus.op = 2'd0; bus.a = 32'd3; bus.b = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rst_mid_hi", bus.hi, 0);
    check("rst_mid_lo", bus.lo, 0);
    check("rst_mid_busy", bus.busy, 0);
    check("rst_mid_done", bus.done, 0);
    @(negedge clk);
    reset_n = 1'b1;
    model_hi = '0;
    model_lo = '0;
    watch_no_done("rst_no_done");

    // randomized ops issued back to back against the reference model
    for (int i = 0; i < 50; i++) begin
      o = 2'($urandom_range(0, 3));
      x = pick();
      y = pick();
      e = model(o, x, y);
      run_op(o, x, y, e[63:32], e[31:0], -1, 0, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
